bcd_multi_counter: RTL and testbench
====================================

BCD_MULTI_COUNTER -- requirements
Module: bcd_multi_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 500000, clk cycles per count tick (>=2).
REQ-003 SHALL have parameter SCAN_DIV, default 5000, clk cycles per display digit slot (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  count enable, sampled on tick cycles.
REQ-007 SHALL have port up_dn  input  1  direction, 1=up, 0=down (used only per REQ-024).
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-010 SHALL have port cnt_out  output  4*DIGITS  registered BCD count, digit 0 least significant.
REQ-011 SHALL have port carry  output  1  one-cycle wrap pulse.
REQ-012 SHALL have port FND  output  7  segments {a,b,c,d,e,f,g}, active-high, for selected digit.
REQ-013 SHALL have port FNDSel  output  DIGITS  one-hot digit select, active-low.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick asserted internally in the cycle prescaler = TICK_DIV-1; prescaler runs regardless of en.
REQ-015 On tick with en=1 and load=0, count SHALL advance by one decimal step on the same clk edge (cnt_out visible next cycle); en=0 holds count.
REQ-016 Up step: digit 9 SHALL roll to 0 and increment next digit; all-9s SHALL wrap to all-0s.
REQ-017 carry SHALL be 1 for exactly the cycle after a wrap (all-9s->all-0s up, all-0s->all-9s down), otherwise 0.
REQ-018 load=1 SHALL write load_val into count on the next edge, any cycle, priority over tick; load SHALL also clear the prescaler to 0; load SHALL not assert carry.
REQ-019 Any load_val digit >9 SHALL be loaded as 0; other digits load unchanged.
REQ-020 Scan divider SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 scan index SHALL advance 0,1,..,DIGITS-1,0.
REQ-021 FNDSel SHALL drive bit[index] low, all others high; FND SHALL show the current cnt_out digit at that index, both registered, updating one cycle after index or count change.
REQ-022 Segment codes: 0=1111110,1=0110000,2=1101101,3=1111001,4=0110011,5=1011011,6=1011111,7=1110000,8=1111111,9=1110011; no other digit value reachable.

Reset
REQ-023 reset=1 SHALL asynchronously force: count/cnt_out=0, carry=0, prescaler=0, scan divider=0, scan index=0, FNDSel={all 1 except bit0=0}, FND=1111110; reset mid-count discards progress; first tick occurs TICK_DIV cycles after reset release.

Configuration
REQ-024 Macro BCD_MULTI_COUNTER_UPDOWN_EN defined: up_dn=0 SHALL count down (digit 0 borrows to 9 and decrements next digit; all-0s wraps to all-9s with carry); undefined: up_dn SHALL be ignored and count is always up, no down logic synthesised.

Verification (DIGITS=2, TICK_DIV=4, SCAN_DIV=2)
REQ-025 Reset release, en=1, up -> cnt_out 0x00, 0x01 after 4 cycles, 0x09->0x10 on 10th tick, FND/FNDSel match REQ-022.
REQ-026 load_val=0x99, load 1 cycle, en=1, up -> cnt_out 0x99, next tick 0x00 with carry=1 for exactly one cycle.
REQ-027 load_val=0xA7 -> cnt_out 0x07; load on a tick cycle -> cnt_out=load_val, no increment, next tick 4 cycles later.
REQ-028 Scan: cnt_out=0x42 held (en=0) -> FNDSel alternates 10/01 every 2 cycles, FND 0110011 when FNDSel=01 (digit 0=2 shows 1101101 when FNDSel=10... digit index 0 -> FNDSel=10 shows 1101101, index 1 -> FNDSel=01 shows 0110011).
REQ-029 With macro, up_dn=0, load 0x00 -> next tick 0x99, carry=1; without macro same stimulus -> 0x01, carry=0.
REQ-030 reset pulsed mid-count at cnt_out=0x37 -> outputs immediately (no clk edge) at REQ-023 values.

Source files
------------

// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD counter with tick prescaler, parallel load and multiplexed 7-segment scan.
// Define BCD_MULTI_COUNTER_UPDOWN_EN to enable down counting via up_dn.
module bcd_multi_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned SCAN_DIV = 5000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt_out,
    output logic                  carry,
    output logic [6:0]            FND,
    output logic [DIGITS-1:0]     FNDSel
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         presc_q;
    logic [SW-1:0]         scan_div_q;
    logic [IW-1:0]         scan_idx_q;
    logic [4*DIGITS-1:0]   cnt_q;
    logic                  carry_q;
    logic [6:0]            fnd_q;
    logic [DIGITS-1:0]     fndsel_q;

    logic                  tick;
    logic                  scan_step;
    logic [4*DIGITS-1:0]   inc_cnt;
    logic                  inc_chain;
    logic [4*DIGITS-1:0]   next_cnt;
    logic                  wrap;
    logic [4*DIGITS-1:0]   load_clean;
    logic [3:0]            disp_digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1110011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

`ifdef BCD_MULTI_COUNTER_UPDOWN_EN
    logic [4*DIGITS-1:0]   dec_cnt;
    logic                  dec_chain;

    always_comb begin
        dec_cnt   = cnt_q;
        dec_chain = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_chain) begin
                if (dec_cnt[4*i +: 4] == 4'd0) begin
                    dec_cnt[4*i +: 4] = 4'd9;
                end else begin
                    dec_cnt[4*i +: 4] = dec_cnt[4*i +: 4] - 4'd1;
                    dec_chain = 1'b0;
                end
            end
        end
    end
`else
    // Direction input has no effect when down counting is not built.
    logic unused_up_dn;
    assign unused_up_dn = up_dn;
`endif

    always_comb begin
        tick      = (presc_q == PW'(TICK_DIV - 1));
        scan_step = (scan_div_q == SW'(SCAN_DIV - 1));

        inc_cnt   = cnt_q;
        inc_chain = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_chain) begin
                if (inc_cnt[4*i +: 4] == 4'd9) begin
                    inc_cnt[4*i +: 4] = 4'd0;
                end else begin
                    inc_cnt[4*i +: 4] = inc_cnt[4*i +: 4] + 4'd1;
                    inc_chain = 1'b0;
                end
            end
        end

`ifdef BCD_MULTI_COUNTER_UPDOWN_EN
        next_cnt = up_dn ? inc_cnt : dec_cnt;
        wrap     = up_dn ? inc_chain : dec_chain;
`else
        next_cnt = inc_cnt;
        wrap     = inc_chain;
`endif

        // Non-BCD nibbles are forced to zero so the count stays decimal.
        load_clean = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
            end
        end

        disp_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == IW'(i)) begin
                disp_digit = cnt_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            scan_div_q <= '0;
            scan_idx_q <= '0;
            fnd_q      <= 7'b1111110;
            fndsel_q   <= ~DIGITS'(1);
        end else begin
            carry_q <= 1'b0;
            if (load) begin
                cnt_q   <= load_clean;
                presc_q <= '0;
            end else begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick && en) begin
                    cnt_q   <= next_cnt;
                    carry_q <= wrap;
                end
            end

            if (scan_step) begin
                scan_div_q <= '0;
                scan_idx_q <= (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
            end else begin
                scan_div_q <= scan_div_q + SW'(1);
            end

            fnd_q    <= seg7(disp_digit);
            fndsel_q <= ~(DIGITS'(1) << scan_idx_q);
        end
    end

    assign cnt_out = cnt_q;
    assign carry   = carry_q;
    assign FND     = fnd_q;
    assign FNDSel  = fndsel_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed self-checking bench for bcd_multi_counter (DIGITS=2, TICK_DIV=4, SCAN_DIV=2).
// Expected values follow BCD_MULTI_COUNTER_UPDOWN_EN when it is defined for the build.
module tb_bcd_multi_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] cnt_out;
    logic       carry;
    logic [6:0] FND;
    logic [1:0] FNDSel;

    int passed = 0;
    int total  = 0;

    bcd_multi_counter #(
        .DIGITS   (2),
        .TICK_DIV (4),
        .SCAN_DIV (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .cnt_out  (cnt_out),
        .carry    (carry),
        .FND      (FND),
        .FNDSel   (FNDSel)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [1:0] sel0;
        logic [1:0] exp_sel;
        int         seen;
        int         phase;

        reset    = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        step(2);
        chk("reset_cnt", {24'd0, cnt_out}, 32'h00);
        chk("reset_carry", {31'd0, carry}, 32'h0);
        chk("reset_fnd", {25'd0, FND}, 32'b1111110);
        chk("reset_fndsel", {30'd0, FNDSel}, 32'b10);

        // Count up from reset: first tick TICK_DIV cycles after release.
        reset = 1'b0;
        en    = 1'b1;
        step(3);
        chk("pre_first_tick", {24'd0, cnt_out}, 32'h00);
        step(1);
        chk("first_tick", {24'd0, cnt_out}, 32'h01);
        step(32);
        chk("tick9", {24'd0, cnt_out}, 32'h09);
        step(4);
        chk("digit_roll", {24'd0, cnt_out}, 32'h10);
        chk("no_carry_roll", {31'd0, carry}, 32'h0);

        // Wrap from all nines.
        load_val = 8'h99;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        chk("load99", {24'd0, cnt_out}, 32'h99);
        chk("load_no_carry", {31'd0, carry}, 32'h0);
        step(3);
        chk("hold99", {24'd0, cnt_out}, 32'h99);
        step(1);
        chk("wrap00", {24'd0, cnt_out}, 32'h00);
        chk("wrap_carry", {31'd0, carry}, 32'h1);
        step(1);
        chk("carry_one_cycle", {31'd0, carry}, 32'h0);

        // Invalid digit sanitised; load on a tick cycle wins and restarts prescaler.
        load_val = 8'hA7;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        chk("load_a7", {24'd0, cnt_out}, 32'h07);
        step(3);
        load_val = 8'h55;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        chk("load_on_tick", {24'd0, cnt_out}, 32'h55);
        step(3);
        chk("hold_after_load", {24'd0, cnt_out}, 32'h55);
        step(1);
        chk("tick_after_load", {24'd0, cnt_out}, 32'h56);

        // Scan with count held at 0x42.
        en       = 1'b0;
        load_val = 8'h42;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        chk("hold42", {24'd0, cnt_out}, 32'h42);
        sel0 = FNDSel;
        seen = 0;
        for (int i = 0; i < 4 && seen == 0; i++) begin
            step(1);
            if (FNDSel !== sel0) seen = 1;
        end
        chk("scan_toggles", seen, 1);
        exp_sel = FNDSel;
        phase   = 0;
        for (int k = 0; k < 6; k++) begin
            chk("scan_sel", {30'd0, FNDSel}, {30'd0, exp_sel});
            chk("scan_fnd", {25'd0, FND},
                (exp_sel == 2'b10) ? 32'b1101101 : 32'b0110011);
            step(1);
            phase++;
            if (phase == 2) begin
                phase   = 0;
                exp_sel = (exp_sel == 2'b10) ? 2'b01 : 2'b10;
            end
        end

        // Count direction with up_dn=0 from zero.
        up_dn    = 1'b0;
        en       = 1'b1;
        load_val = 8'h00;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        chk("dn_pre_tick", {24'd0, cnt_out}, 32'h00);
        step(1);
`ifdef BCD_MULTI_COUNTER_UPDOWN_EN
        chk("dn_wrap", {24'd0, cnt_out}, 32'h99);
        chk("dn_carry", {31'd0, carry}, 32'h1);
`else
        chk("dn_ignored", {24'd0, cnt_out}, 32'h01);
        chk("dn_no_carry", {31'd0, carry}, 32'h0);
`endif

        // Asynchronous reset mid-count.
        up_dn    = 1'b1;
        load_val = 8'h37;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        chk("load37", {24'd0, cnt_out}, 32'h37);
        step(2);
        #2 reset = 1'b1;
        #1;
        chk("async_cnt", {24'd0, cnt_out}, 32'h00);
        chk("async_carry", {31'd0, carry}, 32'h0);
        chk("async_fnd", {25'd0, FND}, 32'b1111110);
        chk("async_fndsel", {30'd0, FNDSel}, 32'b10);
        #1 reset = 1'b0;
        step(3);
        chk("post_reset_hold", {24'd0, cnt_out}, 32'h00);
        step(1);
        chk("post_reset_tick", {24'd0, cnt_out}, 32'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
